// File: rtl/sad_pkg.sv
// Shared definitions for the SAD pipeline stages.
//   SAD_W_DEFAULT : default SAD sample width
//   sad_state_e   : IDLE / SCAN / DONE control states used by SAD-stage blocks
package sad_pkg;

  localparam int unsigned SAD_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } sad_state_e;

endpackage : sad_pkg

// File: rtl/sad_pos_counter.sv
// Raster position counter, column-fastest, for a FRAME_H x FRAME_W window grid.
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset, clears position to (0,0)
//   clear   : synchronous clear to (0,0)
//   advance : step to the next raster position
//   row/col : current position
//   last_c  : current position is (FRAME_H-1, FRAME_W-1)
module sad_pos_counter #(
  parameter int unsigned FRAME_W = 61,
  parameter int unsigned FRAME_H = 61
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       advance,
  output logic [$clog2(FRAME_H)-1:0] row,
  output logic [$clog2(FRAME_W)-1:0] col,
  output logic                       last_c
);

  localparam int unsigned ROW_W = $clog2(FRAME_H);
  localparam int unsigned COL_W = $clog2(FRAME_W);

  logic col_end_c;
  logic row_end_c;

  assign col_end_c = (col == COL_W'(FRAME_W - 1));
  assign row_end_c = (row == ROW_W'(FRAME_H - 1));
  assign last_c    = col_end_c && row_end_c;

  // Column wraps after FRAME_W-1 and carries into the row; the whole frame wraps at the end.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_end_c) begin
        col <= '0;
        row <= row_end_c ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule : sad_pos_counter

// File: rtl/sad_min_tracker.sv
// Tracks the minimum SAD over a FRAME_H x FRAME_W raster scan and reports its position.
//   Clk, Reset          : clock, synchronous active-high reset
//   Start               : one-cycle request to begin a scan (honoured only in IDLE)
//   InValid/InReady/InSAD : sample stream, one SAD per raster position
//   OutValid/OutReady   : result handshake, held in DONE until accepted
//   BestSAD/BestRow/BestCol : minimum SAD of the scan and its (row, col)
// Optional: define SAD_MIN_ZERO_EXIT_EN to end a scan as soon as a zero SAD is accepted.
module sad_min_tracker
  import sad_pkg::*;
#(
  parameter int unsigned FRAME_W = 61,
  parameter int unsigned FRAME_H = 61,
  parameter int unsigned SAD_W   = SAD_W_DEFAULT
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [SAD_W-1:0]           InSAD,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [SAD_W-1:0]           BestSAD,
  output logic [$clog2(FRAME_H)-1:0] BestRow,
  output logic [$clog2(FRAME_W)-1:0] BestCol
);

  localparam int unsigned ROW_W = $clog2(FRAME_H);
  localparam int unsigned COL_W = $clog2(FRAME_W);

  sad_state_e       state;
  logic [ROW_W-1:0] pos_row;
  logic [COL_W-1:0] pos_col;
  logic             pos_last_c;
  logic             accept_c;
  logic             first_c;
  logic             better_c;
  logic             zero_hit_c;
  logic             finish_c;
  logic             clear_c;

  // InReady is a registered copy of (state == SCAN).
  assign accept_c = InValid && InReady;
  assign clear_c  = (state == IDLE) && Start;

  // Counter is cleared on Start, so (0,0) marks the first sample of the scan.
  assign first_c  = (pos_row == '0) && (pos_col == '0);
  assign better_c = first_c || (InSAD < BestSAD);

`ifdef SAD_MIN_ZERO_EXIT_EN
  assign zero_hit_c = (InSAD == '0);
`else
  assign zero_hit_c = 1'b0;
`endif

  assign finish_c = pos_last_c || zero_hit_c;

  sad_pos_counter #(
    .FRAME_W (FRAME_W),
    .FRAME_H (FRAME_H)
  ) u_pos (
    .clk     (Clk),
    .reset   (Reset),
    .clear   (clear_c),
    .advance (accept_c),
    .row     (pos_row),
    .col     (pos_col),
    .last_c  (pos_last_c)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      InReady  <= 1'b0;
      OutValid <= 1'b0;
      BestSAD  <= '1;
      BestRow  <= '0;
      BestCol  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state   <= SCAN;
            InReady <= 1'b1;
          end
        end
        SCAN: begin
          if (accept_c) begin
            if (better_c) begin
              BestSAD <= InSAD;
              BestRow <= pos_row;
              BestCol <= pos_col;
            end
            if (finish_c) begin
              state    <= DONE;
              InReady  <= 1'b0;
              OutValid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (OutReady) begin
            state    <= IDLE;
            OutValid <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          InReady  <= 1'b0;
          OutValid <= 1'b0;
        end
      endcase
    end
  end

endmodule : sad_min_tracker

// File: tb/tb_sad_min_tracker.sv
// Directed bench for sad_min_tracker on a 2x3 raster.
module tb_sad_min_tracker;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        InValid;
  logic        InReady;
  logic [11:0] InSAD;
  logic        OutValid;
  logic        OutReady;
  logic [11:0] BestSAD;
  logic [0:0]  BestRow;
  logic [1:0]  BestCol;

  int n_cmp = 0;
  int n_bad = 0;

  sad_min_tracker #(
    .FRAME_W (3),
    .FRAME_H (2),
    .SAD_W   (12)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .InValid  (InValid),
    .InReady  (InReady),
    .InSAD    (InSAD),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .BestSAD  (BestSAD),
    .BestRow  (BestRow),
    .BestCol  (BestCol)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_scan();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Present one sample and hold it until accepted (bounded wait).
  task automatic feed(input logic [11:0] s);
    bit got_it;
    got_it  = 1'b0;
    InValid = 1'b1;
    InSAD   = s;
    for (int i = 0; i < 20 && !got_it; i++) begin
      if (InReady) got_it = 1'b1;
      tick();
    end
    InValid = 1'b0;
    if (!got_it) check("feed_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [11:0] sad,
                              input logic [0:0] r, input logic [1:0] c);
    check({tag, "_ov"},  32'(OutValid), 32'd1);
    check({tag, "_sad"}, 32'(BestSAD),  32'(sad));
    check({tag, "_row"}, 32'(BestRow),  32'(r));
    check({tag, "_col"}, 32'(BestCol),  32'(c));
  endtask

  task automatic take_result(input string tag);
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    check({tag, "_idle_ov"}, 32'(OutValid), 32'd0);
    check({tag, "_idle_rdy"}, 32'(InReady), 32'd0);
  endtask

  initial begin
    Reset    = 1'b1;
    Start    = 1'b0;
    InValid  = 1'b0;
    InSAD    = '0;
    OutReady = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    check("rst_rdy", 32'(InReady),  32'd0);
    check("rst_ov",  32'(OutValid), 32'd0);
    check("rst_sad", 32'(BestSAD),  32'hFFF);
    check("rst_row", 32'(BestRow),  32'd0);
    check("rst_col", 32'(BestCol),  32'd0);

    // Basic minimum search.
    start_scan();
    check("t1_rdy", 32'(InReady), 32'd1);
    feed(12'd9); feed(12'd7); feed(12'd8); feed(12'd7); feed(12'd5);
    check("t1_ov_early", 32'(OutValid), 32'd0);
    feed(12'd6);
    check("t1_rdy_done", 32'(InReady), 32'd0);
    check_result("t1", 12'd5, 1'b1, 2'd1);
    take_result("t1");

    // Ties keep the earliest position.
    start_scan();
    feed(12'd4); feed(12'd4); feed(12'd9); feed(12'd9); feed(12'd9); feed(12'd9);
    check_result("t2", 12'd4, 1'b0, 2'd0);
    take_result("t2");

    // Stalls: invalid cycles carry small SADs that must be ignored.
    start_scan();
    feed(12'd10);
    InSAD = 12'd1; tick();
    feed(12'd3);
    InSAD = 12'd0; tick();
    feed(12'd8); feed(12'd7); feed(12'd9);
    check("t3_ov_early", 32'(OutValid), 32'd0);
    feed(12'd9);
    for (int i = 0; i < 5; i++) begin
      check_result("t3_hold", 12'd3, 1'b0, 2'd1);
      check("t3_hold_rdy", 32'(InReady), 32'd0);
      tick();
    end
    take_result("t3");
    check("t3_idle_sad", 32'(BestSAD), 32'd3);
    check("t3_idle_col", 32'(BestCol), 32'd1);

    // Reset mid-scan, then a fresh scan restarts at (0,0).
    start_scan();
    feed(12'd5); feed(12'd6); feed(12'd7);
    Reset = 1'b1; Start = 1'b1; InValid = 1'b1;
    tick();
    Reset = 1'b0; Start = 1'b0; InValid = 1'b0;
    check("t4_rdy", 32'(InReady),  32'd0);
    check("t4_ov",  32'(OutValid), 32'd0);
    check("t4_sad", 32'(BestSAD),  32'hFFF);
    start_scan();
    feed(12'd9); feed(12'd9); feed(12'd9); feed(12'd9); feed(12'd9);
    check("t4_ov_early", 32'(OutValid), 32'd0);
    feed(12'd1);
    check_result("t4", 12'd1, 1'b1, 2'd2);
    take_result("t4");

    // Zero SAD handling.
    start_scan();
    feed(12'd6); feed(12'd0);
`ifdef SAD_MIN_ZERO_EXIT_EN
    check("t5_rdy", 32'(InReady), 32'd0);
`else
    check("t5_ov_early", 32'(OutValid), 32'd0);
    check("t5_rdy", 32'(InReady), 32'd1);
    feed(12'd9); feed(12'd0); feed(12'd9); feed(12'd9);
`endif
    check_result("t5", 12'd0, 1'b0, 2'd1);
    take_result("t5");

    // Start during SCAN and DONE is ignored.
    start_scan();
    feed(12'd8); feed(12'd6);
    Start = 1'b1;
    feed(12'd7);
    Start = 1'b0;
    feed(12'd7); feed(12'd7);
    check("t6_ov_early", 32'(OutValid), 32'd0);
    feed(12'd7);
    check_result("t6", 12'd6, 1'b0, 2'd1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check_result("t6_start", 12'd6, 1'b0, 2'd1);
    check("t6_start_rdy", 32'(InReady), 32'd0);
    take_result("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sad_min_tracker

// File: doc/sad_min_tracker.md
SAD_MIN_TRACKER -- requirements
Module: sad_min_tracker

Interface
REQ-001 SHALL have parameter FRAME_W, default 61, meaning the number of window positions per row in the search raster.
REQ-002 SHALL have parameter FRAME_H, default 61, meaning the number of window rows in the search raster.
REQ-003 SHALL have parameter SAD_W, default 12, meaning the width of each incoming SAD value.
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port Start, input, 1 bit: a one-cycle request to begin a new scan.
REQ-007 SHALL have port InValid, input, 1 bit: InSAD carries a valid sample.
REQ-008 SHALL have port InReady, output, 1 bit: the block can accept a sample.
REQ-009 SHALL have port InSAD, input, SAD_W bits: the SAD for the current raster position.
REQ-010 SHALL have port OutValid, output, 1 bit: the best-match result is valid.
REQ-011 SHALL have port OutReady, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port BestSAD, output, SAD_W bits: the minimum SAD of the scan.
REQ-013 SHALL have port BestRow, output, $clog2(FRAME_H) bits: the row of the minimum.
REQ-014 SHALL have port BestCol, output, $clog2(FRAME_W) bits: the column of the minimum.

Function
REQ-015 SHALL implement states IDLE, SCAN and DONE.
REQ-016 SHALL transition IDLE->SCAN on Start; Start in SCAN or DONE is ignored.
REQ-017 SHALL drive InReady=1 only in SCAN; a sample is accepted when InValid && InReady.
REQ-018 SHALL assign accepted samples raster positions, column-fastest: (0,0),(0,1)..(0,FRAME_W-1),(1,0)..; the column wraps to 0 and the row increments after column FRAME_W-1.
REQ-019 SHALL load the first accepted sample of a scan unconditionally as the best.
REQ-020 SHALL, for later samples, update the best only on strict less-than; ties keep the earliest raster position.
REQ-021 SHALL perform the comparison with unsigned SAD_W-bit arithmetic, with no saturation or truncation.
REQ-022 SHALL transition SCAN->DONE in the cycle the sample at (FRAME_H-1,FRAME_W-1) is accepted, and raise OutValid on the next cycle (1-cycle latency from the last acceptance).
REQ-023 SHALL hold OutValid, BestSAD, BestRow and BestCol stable in DONE until OutValid && OutReady, then transition DONE->IDLE.
REQ-024 SHALL keep the raster position unchanged on cycles where InValid=1 and InReady=0, or InValid=0 (stall).
REQ-025 SHALL keep Best* outputs holding the last result in IDLE, with OutValid=0.

Reset
REQ-026 SHALL on Reset=1 at a clock edge enter IDLE; set InReady=0, OutValid=0, BestSAD=all-ones, BestRow=0, BestCol=0; and clear the position counters.
REQ-027 SHALL let Reset abort a scan or a pending result mid-operation, with no partial result emitted.
REQ-028 SHALL give Reset priority over Start, InValid and OutReady in the same cycle.

Configuration
REQ-029 SHALL, with macro SAD_MIN_ZERO_EXIT_EN defined, on acceptance of InSAD==0, record that position as best and transition SCAN->DONE in the same cycle, ending the scan early; InReady=0 from the next cycle.
REQ-030 SHALL, without SAD_MIN_ZERO_EXIT_EN, scan all FRAME_W*FRAME_H positions regardless of value; per REQ-020, later zeros do not replace an earlier zero.

Structure
REQ-031 SHALL take the SAD_W default and the state enumeration (IDLE, SCAN, DONE) from shared package sad_pkg, used by all SAD-stage blocks.
REQ-032 SHALL instantiate one sub-module, sad_pos_counter (row/column raster counter with advance, clear and last-position flag), used here and by the upstream window fetcher.

Verification
REQ-033 SHALL cover: FRAME_W=3, FRAME_H=2, Start, SADs 9,7,8,7,5,6 with continuous InValid -> OutValid 1 cycle after the 6th acceptance; BestSAD=5, Row=1, Col=1.
REQ-034 SHALL cover: ties, SADs 4,4,9,9,9,9 -> BestSAD=4, Row=0, Col=0.
REQ-035 SHALL cover: InValid toggled 1,0,1,0 plus OutReady held 0 for 5 cycles -> positions advance only on acceptance; outputs stable until OutReady=1, then IDLE next cycle.
REQ-036 SHALL cover: Reset asserted after the 3rd acceptance -> next cycle state IDLE, OutValid=0, BestSAD=0xFFF; a new Start restarts at (0,0).
REQ-037 SHALL cover: with SAD_MIN_ZERO_EXIT_EN, SADs 6,0 -> DONE after 2 acceptances, BestSAD=0, Row=0, Col=1; without it, all 6 samples are consumed and the same result is produced.
REQ-038 SHALL cover: Start pulsed during SCAN and during DONE -> ignored, and the scan count is unchanged.
